req_debounce_latch: RTL
=======================

# req_debounce_latch

Four-channel input conditioning stage that sits directly upstream of the 4-to-2 priority encoder on the Basys 3 board. It synchronises and debounces four raw push-button or switch inputs. In latch mode it holds each press as a pending request bit until the downstream consumer clears that request by index. Its `req` output drives the encoder's 4-bit data input; the encoder's 2-bit index output returns as the clear index.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000 — stable-sample count required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default `$clog2(DB_CYCLES)` — width of each debounce counter; derived, not overridden.

Ports:
- `clk`  input  1  — system clock; all state updates on its rising edge.
- `rst_n`  input  1  — reset, asynchronous and active-low.
- `btn`  input  4  — raw asynchronous inputs, one per channel; bit 3 is the highest priority downstream.
- `latch_en`  input  1  — 1: `req` is the sticky pending register. 0: `req` follows `btn_db` directly.
- `clr_valid`  input  1  — single-cycle strobe that clears one pending bit.
- `clr_idx`  input  2  — channel to clear when `clr_valid` = 1.
- `btn_db`  output  4  — debounced level per channel.
- `req`  output  4  — request vector to the encoder data input.
- `any_req`  output  1  — OR of `req`.

## Operation
- **Synchroniser:** two flops per channel, `btn` → `s1` → `s2`. Only `s2` is used downstream.
- **Debounce:** one counter per channel.
  - `s2` == `btn_db[i]`: the counter clears to 0.
  - `s2` != `btn_db[i]` and counter < `DB_CYCLES-1`: the counter increments.
  - `s2` != `btn_db[i]` and counter == `DB_CYCLES-1`: `btn_db[i]` ← `s2` and the counter ← 0.
  - Any return to agreement before the terminal count discards progress, so a glitch lasting fewer than `DB_CYCLES` consecutive mismatching samples is rejected.
  - The counter never exceeds `DB_CYCLES-1`; there is no wrap-around.
- **Press event:** asserted for channel i on the clock edge where `btn_db[i]` goes 0→1, i.e. terminal count with `s2` = 1. A release (1→0) generates no event.
- **Pending register `pend[3:0]`:**
  - Set: a press event on channel i sets `pend[i]`.
  - Clear: `clr_valid` && `clr_idx` == i clears `pend[i]`.
  - Set and clear on the same channel in the same cycle: set wins, so a new press is never lost.
  - Clears and sets on different channels in the same cycle both take effect.
  - Clearing a bit that is already 0 has no effect.
  - `pend` keeps updating while `latch_en` = 0, so switching modes never loses events.
- **Output select:** `req` = `latch_en` ? `pend` : `btn_db`. This mux is combinational from registers, with no extra latency.
- `any_req` = |`req`, combinational.

## Timing
- **Reset:** while `rst_n` = 0, the `s1`/`s2` flops, counters, `btn_db` and `pend` are all 0. As a result `req` = 0 and `any_req` = 0.
  - An assertion mid-count discards the count and any pending requests immediately, without waiting for a clock.
  - After release, an input already held high is re-accepted as a fresh press after the full latency.
- **Accept latency:** if `btn[i]` rises before clock edge 1 and stays high, `s2` is high after edge 2. `btn_db[i]`, `pend[i]` (latch mode) and `req[i]` all rise at edge `DB_CYCLES+2`.
- **Release latency:** `btn_db[i]` falls at edge `DB_CYCLES+2` after the fall is first sampled. `pend[i]` is unaffected by the release.
- **Clear:** `clr_valid` sampled high at edge k forces `req[clr_idx]` low from edge k onward, unless a simultaneous press event occurs on that channel.
- **Clear-index path:** the clear index may come combinationally from the downstream encoder. The path is `pend` → encoder → `clr_idx` → `pend`, and it is registered at `pend`, so there is no combinational loop.
- **Throughput:** one clear per cycle; up to four press events in the same cycle.

## Test plan
All scenarios use `DB_CYCLES` = 4.
- **Reset values and release:** hold `rst_n` = 0 with `btn` = 4'b1111 → `btn_db` = 0, `req` = 0, `any_req` = 0. Release reset with `btn` held at 4'b1111 → `btn_db` = 4'b1111 and `req` = 4'b1111 at edge 6 after release.
- **Glitch rejection:** `latch_en` = 1; pulse `btn[2]` high for 3 cycles, then low → `btn_db[2]` and `req[2]` stay 0 throughout. Hold `btn[2]` high for ≥ 4 cycles → `req[2]` rises exactly 6 edges after the first high sample; `any_req` = 1.
- **Sticky latch and clear:** press and release `btn[1]` (held 10 cycles) → `req` = 4'b0010 persists after release. Pulse `clr_valid` with `clr_idx` = 1 → `req` = 4'b0000 on the next edge.
- **Set/clear collision:** with `pend[3]` = 1, time `clr_valid`, `clr_idx` = 3 to coincide with a new `btn[3]` press event → `req[3]` stays 1. The same clear with no press → `req[3]` = 0.
- **Mode switch:** `latch_en` = 0 with `btn[0]` held → `req[0]` tracks `btn_db[0]` and falls 6 edges after release. Then set `latch_en` = 1 → `req[0]` = 1, because `pend[0]` was set by the earlier press.
- **Asynchronous reset mid-debounce:** assert `rst_n` = 0 between clock edges, 2 cycles into a `btn[3]` count → all outputs drop to 0 immediately. Release with `btn[3]` still high → `req[3]` rises 6 edges after release.

Source files
------------

// File: rtl/req_debounce_latch.sv
// req_debounce_latch: four-channel synchronise + debounce + sticky request latch.
// Sits in front of a 4-to-2 priority encoder; the encoder index returns as clr_idx.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn[3:0]   raw asynchronous inputs (bit 3 highest priority downstream)
//   latch_en   1: req = sticky pending register, 0: req = debounced level
//   clr_valid  single-cycle strobe clearing pending bit clr_idx
//   clr_idx    channel to clear
//   btn_db     debounced level per channel
//   req        request vector to the encoder (combinational mux of registers)
//   any_req    OR of req
module req_debounce_latch #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       latch_en,
  input  logic       clr_valid,
  input  logic [1:0] clr_idx,
  output logic [3:0] btn_db,
  output logic [3:0] req,
  output logic       any_req
);

  localparam int unsigned N_CH = 4;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  db;
  logic [N_CH-1:0]  db_next;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  pend_next;
  logic [N_CH-1:0]  press;
  logic [N_CH-1:0]  clr_mask;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];

  // Debounce counters: any agreement discards progress; terminal count commits the level.
  always_comb begin
    press   = '0;
    db_next = db;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_TERM) begin
          db_next[i] = s2[i];
          press[i]   = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pending register: set has priority over a clear on the same channel.
  always_comb begin
    clr_mask  = clr_valid ? (N_CH'(1) << clr_idx) : '0;
    pend_next = (pend & ~clr_mask) | press;
  end

  // All state, including the synchroniser, resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      pend <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1   <= btn;
      s2   <= s1;
      db   <= db_next;
      pend <= pend_next;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Output select has no added latency; the clear path is broken at pend.
  always_comb begin
    btn_db  = db;
    req     = latch_en ? pend : db;
    any_req = |req;
  end

endmodule
